// File: rtl/rect_click_detector.sv
// rect_click_detector: registers mouse/rectangle inputs, hit-tests the published
// clickable rectangle, debounces the left button and emits one-cycle click pulses
// (rect_clicked_play / mouse_clicked_stop) for the game state machine.
module rect_click_detector #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic [1:0]  SCORE_STATE     = 2'b11
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        mouse_left,
  input  logic [10:0] hstart_click_play,
  input  logic [10:0] vstart_click_play,
  input  logic [10:0] hlength_click_play,
  input  logic [10:0] vlength_click_play,
  input  logic [1:0]  state,
  output logic        rect_clicked_play,
  output logic        mouse_clicked_stop,
  output logic        hover
);

  localparam int unsigned POS_W = 12;
  localparam int unsigned RECT_W = 11;
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_REL    = 2'd0,
    ST_ARMED  = 2'd1,
    ST_CANCEL = 2'd2,
    ST_SPRESS = 2'd3
  } fsm_t;

  // registered copies of all inputs
  logic [POS_W-1:0]  xpos_q, ypos_q;
  logic              btn_q;
  logic [RECT_W-1:0] hstart_q, vstart_q, hlength_q, vlength_q;
  logic [1:0]        state_q;

  // debounce and FSM state
  logic              db_q;
  logic              db_prev_q;
  logic [CNT_W-1:0]  cnt_q;
  fsm_t              fsm_q, fsm_next_c;
  logic              rect_next_c, stop_next_c;

  logic [POS_W-1:0]  hend_c, vend_c;
  logic              inside_c;
  logic              press_c, release_c;

  // input stage: one register on everything that feeds a decision
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      xpos_q    <= '0;
      ypos_q    <= '0;
      btn_q     <= 1'b0;
      hstart_q  <= '0;
      vstart_q  <= '0;
      hlength_q <= '0;
      vlength_q <= '0;
      state_q   <= '0;
    end else begin
      xpos_q    <= xpos;
      ypos_q    <= ypos;
      btn_q     <= mouse_left;
      hstart_q  <= hstart_click_play;
      vstart_q  <= vstart_click_play;
      hlength_q <= hlength_click_play;
      vlength_q <= vlength_click_play;
      state_q   <= state;
    end
  end

  // hit-test; 11-bit operands summed into 12 bits cannot wrap
  always_comb begin
    hend_c   = POS_W'(hstart_q) + POS_W'(hlength_q);
    vend_c   = POS_W'(vstart_q) + POS_W'(vlength_q);
    inside_c = (hlength_q != '0) && (vlength_q != '0) &&
               (xpos_q >= POS_W'(hstart_q)) && (xpos_q < hend_c) &&
               (ypos_q >= POS_W'(vstart_q)) && (ypos_q < vend_c);
  end

  // debounce: flip after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      db_prev_q <= db_q;
      if (btn_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        db_q  <= btn_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign press_c   = db_q & ~db_prev_q;
  assign release_c = ~db_q & db_prev_q;

  // click FSM next state and pulse decode
  always_comb begin
    fsm_next_c  = fsm_q;
    rect_next_c = 1'b0;
    stop_next_c = 1'b0;
    case (fsm_q)
      ST_REL: begin
        if (press_c) begin
          if (state_q == SCORE_STATE) fsm_next_c = ST_SPRESS;
          else if (inside_c)          fsm_next_c = ST_ARMED;
          else                        fsm_next_c = ST_CANCEL;
        end
      end
      ST_ARMED: begin
        // release outside the rectangle is a cancel, not a click
        if (release_c) begin
          rect_next_c = inside_c;
          fsm_next_c  = ST_REL;
        end else if (db_q && !inside_c) begin
          fsm_next_c = ST_CANCEL;
        end
      end
      ST_CANCEL: begin
        if (release_c) fsm_next_c = ST_REL;
      end
      ST_SPRESS: begin
        if (release_c) begin
          stop_next_c = 1'b1;
          fsm_next_c  = ST_REL;
        end
      end
      default: fsm_next_c = ST_REL;
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q              <= ST_REL;
      rect_clicked_play  <= 1'b0;
      mouse_clicked_stop <= 1'b0;
      hover              <= 1'b0;
    end else begin
      fsm_q              <= fsm_next_c;
      rect_clicked_play  <= rect_next_c;
      mouse_clicked_stop <= stop_next_c;
      hover              <= inside_c;
    end
  end

endmodule
